// File: rtl/psum_acc.sv
// ---------------------------------------------------------------------------
// psum_acc -- partial-sum accumulator behind the MAC stage.
//
// Accumulates `len` signed partial sums into one acc_bw-wide word. ReLU can
// be applied to the finished word, which is then held on a valid/ready
// output until the consumer accepts it.
//
// Valid/ready semantics: a transfer happens on a rising edge where both
// valid and ready are high. A producer keeps its data stable while valid is
// high and ready is low. Valid never waits on ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in         signed partial sum from the MAC (psum_bw bits)
//   in_valid   `in` carries a partial sum this cycle
//   in_ready   block accepts `in` this cycle (low only while a result is held)
//   relu_en    clamp a negative finished result to zero (sampled on last beat)
//   out        signed accumulated result (acc_bw bits)
//   out_valid  `out` holds a finished result
//   out_ready  downstream accepts `out` this cycle
//   busy       state is not IDLE
//
// Build option: define PSUM_ACC_SAT_EN to saturate every accumulate step to
// the signed acc_bw range. Without it the accumulator wraps modulo 2^acc_bw.
// ---------------------------------------------------------------------------
module psum_acc #(
    parameter int psum_bw = 9,
    parameter int acc_bw  = 16,
    parameter int len     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [psum_bw-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              relu_en,
    output logic [acc_bw-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(len + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(len - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [acc_bw-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [acc_bw-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic [acc_bw-1:0] in_ext;
    logic [acc_bw-1:0] sum;
    logic [acc_bw-1:0] relu_sum;
    logic              accept;
    logic              last_beat;

    assign in_ready  = (state_q != HOLD);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign accept    = in_valid && in_ready;

    // acc_q is zero in IDLE, so acc_q + in_ext also yields the first-beat load.
`ifdef PSUM_ACC_SAT_EN
    logic [acc_bw:0] sum_wide;

    always_comb begin
        in_ext   = acc_bw'($signed(in));
        sum_wide = {acc_q[acc_bw-1], acc_q} + {in_ext[acc_bw-1], in_ext};
        // The two top bits disagree only when the step left the signed range.
        if (sum_wide[acc_bw] != sum_wide[acc_bw-1]) begin
            if (sum_wide[acc_bw]) begin
                sum = {1'b1, {(acc_bw-1){1'b0}}};
            end else begin
                sum = {1'b0, {(acc_bw-1){1'b1}}};
            end
        end else begin
            sum = sum_wide[acc_bw-1:0];
        end
    end
`else
    always_comb begin
        in_ext = acc_bw'($signed(in));
        sum    = acc_q + in_ext;
    end
`endif

    always_comb begin
        relu_sum = sum;
        if (relu_en && sum[acc_bw-1]) begin
            relu_sum = '0;
        end
    end

    // With len==1 the very first beat is already the last one.
    always_comb begin
        last_beat = 1'b0;
        if (state_q == IDLE) begin
            last_beat = (len == 1);
        end else if (state_q == ACC) begin
            last_beat = (cnt_q == LAST_CNT);
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        out_d       = relu_sum;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_psum_acc.sv
// ---------------------------------------------------------------------------
// tb_psum_acc -- directed self-checking bench for psum_acc.
//
// Three instances share clock and reset:
//   u_dut0  default parameters (psum_bw=9, acc_bw=16, len=8)
//   u_dut1  acc_bw=10 for the overflow case
//   u_dut2  len=1 for back-to-back results
// Inputs change 1 time unit after a rising edge and outputs are checked at
// the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_psum_acc;

    logic clk;
    logic reset;

    logic [8:0]  in0, in1, in2;
    logic        v0, v1, v2;
    logic        rdy0, rdy1, rdy2;
    logic        relu0, relu1, relu2;
    logic [15:0] out0, out2;
    logic [9:0]  out1;
    logic        ov0, ov1, ov2;
    logic        ordy0, ordy1, ordy2;
    logic        busy0, busy1, busy2;

    int n_cmp;
    int n_bad;

    psum_acc u_dut0 (
        .clk(clk), .reset(reset), .in(in0), .in_valid(v0), .in_ready(rdy0),
        .relu_en(relu0), .out(out0), .out_valid(ov0), .out_ready(ordy0),
        .busy(busy0)
    );

    psum_acc #(.psum_bw(9), .acc_bw(10), .len(8)) u_dut1 (
        .clk(clk), .reset(reset), .in(in1), .in_valid(v1), .in_ready(rdy1),
        .relu_en(relu1), .out(out1), .out_valid(ov1), .out_ready(ordy1),
        .busy(busy1)
    );

    psum_acc #(.psum_bw(9), .acc_bw(16), .len(1)) u_dut2 (
        .clk(clk), .reset(reset), .in(in2), .in_valid(v2), .in_ready(rdy2),
        .relu_en(relu2), .out(out2), .out_valid(ov2), .out_ready(ordy2),
        .busy(busy2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Driver: one beat on u_dut0, accepted at the next edge (in_ready=1).
    task automatic send0(input logic [8:0] val);
        in0 = val;
        v0  = 1'b1;
        tick();
        v0  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        in0 = '0; in1 = '0; in2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        relu0 = 1'b0; relu1 = 1'b0; relu2 = 1'b0;
        ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out", out0, 16'h0000);
        check("rst_out_valid", 16'(ov0), 16'h0000);
        check("rst_busy", 16'(busy0), 16'h0000);
        check("rst_in_ready", 16'(rdy0), 16'h0001);

        // 1..8 back to back -> 36
        for (int i = 1; i <= 8; i++) begin
            send0(9'(i));
            if (i == 7) check("sum_no_early_valid", 16'(ov0), 16'h0000);
        end
        check("sum_out_valid", 16'(ov0), 16'h0001);
        check("sum_out", out0, 16'd36);
        check("sum_in_ready_low", 16'(rdy0), 16'h0000);
        check("sum_busy", 16'(busy0), 16'h0001);
        tick();
        check("sum_valid_drop", 16'(ov0), 16'h0000);
        check("sum_in_ready_back", 16'(rdy0), 16'h0001);
        check("sum_busy_low", 16'(busy0), 16'h0000);

        // Eight -100 -> -800, ReLU off
        for (int i = 0; i < 8; i++) send0(9'h19C);
        check("neg_out", out0, 16'hFCE0);
        tick();

        // Same, ReLU on only for the final beat -> 0
        for (int i = 0; i < 8; i++) begin
            if (i == 7) relu0 = 1'b1;
            send0(9'h19C);
            relu0 = 1'b0;
        end
        check("relu_out", out0, 16'h0000);
        check("relu_valid", 16'(ov0), 16'h0001);
        tick();

        // ReLU high during accumulation but low on the final beat -> -800
        relu0 = 1'b1;
        for (int i = 0; i < 7; i++) send0(9'h19C);
        relu0 = 1'b0;
        send0(9'h19C);
        check("relu_mid_ignored", out0, 16'hFCE0);
        tick();

        // Bubbles + back-pressure: 8 x 5 with 2-cycle gaps -> 40
        ordy0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tick();
            send0(9'd5);
        end
        check("bp_valid", 16'(ov0), 16'h0001);
        check("bp_out", out0, 16'd40);
        // A beat presented during HOLD must not be taken.
        in0 = 9'd99;
        v0  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", 16'(rdy0), 16'h0000);
            tick();
            check("bp_out_stable", out0, 16'd40);
            check("bp_valid_stable", 16'(ov0), 16'h0001);
        end
        v0 = 1'b0;
        ordy0 = 1'b1;
        tick();
        check("bp_released", 16'(ov0), 16'h0000);
        for (int i = 0; i < 8; i++) send0(9'd1);
        check("bp_hold_beat_dropped", out0, 16'd8);
        tick();

        // Reset mid-operation: 3 x 7, reset, 8 x 2 -> 16
        for (int i = 0; i < 3; i++) send0(9'd7);
        check("mid_busy", 16'(busy0), 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 16'(busy0), 16'h0000);
        check("mid_rst_valid", 16'(ov0), 16'h0000);
        check("mid_rst_out", out0, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            send0(9'd2);
            if (i < 7) check("mid_no_stale_valid", 16'(ov0), 16'h0000);
        end
        check("mid_out", out0, 16'd16);
        tick();
        check("mid_single_result", 16'(ov0), 16'h0000);

        // Overflow on acc_bw=10: 8 x 255
        for (int i = 0; i < 8; i++) begin
            in1 = 9'd255;
            v1  = 1'b1;
            tick();
        end
        v1 = 1'b0;
        check("ovf_valid", 16'(ov1), 16'h0001);
`ifdef PSUM_ACC_SAT_EN
        check("ovf_out_sat", 16'(out1), 16'h01FF);
`else
        check("ovf_out_wrap", 16'(out1), 16'h03F8);
`endif
        tick();

        // len=1 back to back, in_valid held high: 3, -4, 9
        in2 = 9'd3;
        v2  = 1'b1;
        tick();
        check("b2b_v0", 16'(ov2), 16'h0001);
        check("b2b_out0", out2, 16'd3);
        check("b2b_rdy_low", 16'(rdy2), 16'h0000);
        in2 = 9'h1FC;
        tick();
        check("b2b_gap", 16'(ov2), 16'h0000);
        tick();
        check("b2b_v1", 16'(ov2), 16'h0001);
        check("b2b_out1", out2, 16'hFFFC);
        in2 = 9'd9;
        tick();
        tick();
        check("b2b_v2", 16'(ov2), 16'h0001);
        check("b2b_out2", out2, 16'd9);
        v2 = 1'b0;
        tick();
        check("b2b_idle", 16'(busy2), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
